// File: rtl/clk_div_pkg.sv
`timescale 1ns/1ps
// Shared types and default constants for the multi-channel clock divider.
package clk_div_pkg;

    // Output behaviour of a channel.
    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_CNT_W  = 25;
    localparam int DEFAULT_DIV    = 25000000;
    localparam int DEFAULT_MODE   = 0;

    // Width of the channel select; never narrower than one bit.
    function automatic int addr_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
`timescale 1ns/1ps
// Configuration write bus of the divider: one strobe plus channel, divisor and mode.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CNT_W  = DEFAULT_CNT_W
);
    localparam int ADDR_W = addr_width(NUM_CH);

    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [CNT_W-1:0]  cfg_div;
    mode_e             cfg_mode;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_div,
        output cfg_mode
    );

    modport slave (
        input cfg_we,
        input cfg_addr,
        input cfg_div,
        input cfg_mode
    );

endinterface

// File: rtl/clk_div_chan.sv
`timescale 1ns/1ps
// One divider channel: counter, active/pending settings and registered outputs.
// New settings are staged in the pending registers and only become active at a
// period boundary (terminal count) or while the channel is disabled, so the
// output never sees a shortened or stretched period.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W    = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV),
    parameter mode_e            DEF_MODE = MODE_TOGGLE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_div,
    input  mode_e            wr_mode,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] pend_div;
    mode_e            act_mode;
    mode_e            pend_mode;

    logic [CNT_W-1:0] next_pend_div;
    mode_e            next_pend_mode;
    logic             halted;
    logic             terminal;

    // A write landing on the same edge as a transfer is forwarded straight to active.
    always_comb begin
        next_pend_div  = pend_div;
        next_pend_mode = pend_mode;
        if (we) begin
            next_pend_div  = wr_div;
            next_pend_mode = wr_mode;
        end
        halted   = (act_div == '0);
        terminal = !halted && (cnt >= act_div - 1'b1);
    end

    // Counter, settings and output registers, all cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            act_div   <= DEF_DIV;
            pend_div  <= DEF_DIV;
            act_mode  <= DEF_MODE;
            pend_mode <= DEF_MODE;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            pend_div  <= next_pend_div;
            pend_mode <= next_pend_mode;
            if (!en) begin
                cnt      <= '0;
                tick     <= 1'b0;
                clk_out  <= 1'b0;
                act_div  <= next_pend_div;
                act_mode <= next_pend_mode;
            end else if (halted) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (terminal) begin
                cnt      <= '0;
                tick     <= 1'b1;
                clk_out  <= (act_mode == MODE_PULSE) ? 1'b1 : ~clk_out;
                act_div  <= next_pend_div;
                act_mode <= next_pend_mode;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
                if (act_mode == MODE_PULSE) begin
                    clk_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
`timescale 1ns/1ps
// Bank of independent programmable clock dividers sharing one config write bus.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = DEFAULT_NUM_CH,
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int DEF_DIV  = DEFAULT_DIV,
    parameter int DEF_MODE = DEFAULT_MODE
) (
    input  logic              clock,
    input  logic              reset,
    clk_div_multi_if.slave    cfg,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int    ADDR_W       = addr_width(NUM_CH);
    localparam mode_e RESET_MODE   = (DEF_MODE != 0) ? MODE_PULSE : MODE_TOGGLE;
    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEF_DIV);

    logic [NUM_CH-1:0] wr_strobe;

    // Addresses beyond the last channel match no strobe, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign wr_strobe[i] = cfg.cfg_we && (cfg.cfg_addr == ADDR_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (RESET_DIV),
            .DEF_MODE(RESET_MODE)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .en     (ch_en[i]),
            .we     (wr_strobe[i]),
            .wr_div (cfg.cfg_div),
            .wr_mode(cfg.cfg_mode),
            .clk_out(clk_out[i]),
            .tick   (tick[i])
        );
    end

endmodule
